// File: rtl/tdm_demux4_rx.sv
// Receive side of the 4-channel TDM link: finds frame sync, cuts the serial
// stream into four W-bit slots and writes each completed word to its channel.
module tdm_demux4_rx #(
  parameter int W        = 8,
  parameter bit FS_CHECK = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         din,
  input  logic         fs,
  input  logic         clr_err,
  output logic [W-1:0] ch0_data,
  output logic [W-1:0] ch1_data,
  output logic [W-1:0] ch2_data,
  output logic [W-1:0] ch3_data,
  output logic [3:0]   ch_valid,
  output logic         frame_done,
  output logic [1:0]   slot,
  output logic         locked,
  output logic         sync_err
);

  localparam int              CW   = (W > 2) ? $clog2(W) : 1;
  localparam logic [CW-1:0]   LAST = CW'(W - 1);
  localparam logic [0:0]      HUNT = 1'b0;
  localparam logic [0:0]      RUN  = 1'b1;

  logic [0:0]          state_q, state_d;
  logic [W-2:0]        sr_q, sr_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [1:0]          slot_q, slot_d;
  logic [3:0][W-1:0]   ch_q, ch_d;
  logic [3:0]          vld_q, vld_d;
  logic                fd_q, fd_d;
  logic                err_q, err_d;
  logic                err_set;
  logic                at_start;
  logic [W-1:0]        word;

  assign word     = {sr_q, din};
  assign at_start = (slot_q == 2'd0) && (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    slot_d  = slot_q;
    ch_d    = ch_q;
    vld_d   = '0;
    fd_d    = 1'b0;
    err_set = 1'b0;
    if (en) begin
      case (state_q)
        HUNT: begin
          if (fs) begin
            state_d  = RUN;
            sr_d     = '0;
            sr_d[0]  = din;
            cnt_d    = CW'(1);
            slot_d   = 2'd0;
          end
        end
        RUN: begin
          if (fs && !at_start) begin
            // Early sync: drop the partial word and realign on this bit.
            err_set = 1'b1;
            sr_d    = '0;
            sr_d[0] = din;
            cnt_d   = CW'(1);
            slot_d  = 2'd0;
          end else if (!fs && at_start && FS_CHECK) begin
            err_set = 1'b1;
            state_d = HUNT;
            sr_d    = '0;
            cnt_d   = '0;
            slot_d  = 2'd0;
          end else begin
            sr_d = word[W-2:0];
            if (cnt_q == LAST) begin
              ch_d[slot_q]  = word;
              vld_d[slot_q] = 1'b1;
              fd_d          = (slot_q == 2'd3);
              cnt_d         = '0;
              slot_d        = slot_q + 2'd1;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
    // A fresh error outranks a simultaneous clear.
    err_d = err_set ? 1'b1 : (clr_err ? 1'b0 : err_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= HUNT;
      sr_q    <= '0;
      cnt_q   <= '0;
      slot_q  <= 2'd0;
      ch_q    <= '0;
      vld_q   <= '0;
      fd_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      slot_q  <= slot_d;
      ch_q    <= ch_d;
      vld_q   <= vld_d;
      fd_q    <= fd_d;
      err_q   <= err_d;
    end
  end

  assign ch0_data   = ch_q[0];
  assign ch1_data   = ch_q[1];
  assign ch2_data   = ch_q[2];
  assign ch3_data   = ch_q[3];
  assign ch_valid   = vld_q;
  assign frame_done = fd_q;
  assign slot       = slot_q;
  assign locked     = (state_q == RUN);
  assign sync_err   = err_q;

endmodule

// File: doc/tdm_demux4_rx.md
Name: tdm_demux4_rx

Overview:
- Receive side of the team's 4-channel time-division link: the inverse of the 4:1 select mux.
- Takes a serial bit stream with a frame-sync marker and cuts it into four fixed-width slots.
- Deserialises each slot MSB-first and writes it to that slot's channel output register.
- Raises a one-cycle valid for the channel that was written.
- Tracks frame alignment and flags sync errors.

Parameters:
- W, 8, bits per slot (W >= 2).
- FS_CHECK, 1: 1 = a missing fs at the expected frame start drops lock; 0 = free-run once locked.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  bit strobe; din/fs are sampled only on edges where en=1.
- din  input  1  serial data bit.
- fs  input  1  frame sync; high with bit 0 (MSB) of slot 0.
- clr_err  input  1  synchronous clear of sync_err.
- ch0_data  output  W  last completed slot-0 word.
- ch1_data  output  W  last completed slot-1 word.
- ch2_data  output  W  last completed slot-2 word.
- ch3_data  output  W  last completed slot-3 word.
- ch_valid  output  4  one-hot, one-cycle pulse; bit n means chn_data was just updated.
- frame_done  output  1  one-cycle pulse, coincident with ch_valid[3].
- slot  output  2  current slot index (0 in HUNT).
- locked  output  1  1 in RUN state.
- sync_err  output  1  sticky error flag.

Behaviour:
- Reset (async, rst=1):
  - State HUNT; shift register, bit_cnt and slot = 0.
  - All chN_data = 0; ch_valid, frame_done, locked and sync_err = 0.
- All state updates are on rising clk edges where en=1, except clr_err and the pulse deassertion.
- With en=0: all state holds, and ch_valid/frame_done are 0 on the next edge.
- HUNT:
  - din is ignored while fs=0.
  - On en&fs: din is shifted in as bit 0, bit_cnt becomes 1, slot becomes 0, state goes to RUN, locked goes to 1.
- RUN, per en edge:
  - sr <= {sr[W-2:0], din}; bit_cnt increments.
  - When bit_cnt == W-1 at the edge, the word {sr[W-2:0], din} is written to ch[slot]:
    - ch_valid[slot] is 1 for the following cycle.
    - bit_cnt resets to 0; slot increments, wrapping 3 -> 0.
    - When slot was 3, frame_done is also pulsed.
  - Latency: a word is visible on chN_data, together with its ch_valid pulse, immediately after the edge that samples its last bit.
  - chN_data holds its value until that slot is next completed.
- fs in RUN at the expected position (slot=0, bit_cnt=0): normal, no action.
- fs in RUN at any other position:
  - sync_err is set and the partial word is discarded (no ch_valid).
  - The current bit is taken as slot 0 bit 0: bit_cnt=1, slot=0, stays RUN.
- fs missing at the expected position, FS_CHECK=1:
  - sync_err is set; state goes to HUNT, locked=0, slot=0.
  - The bit is discarded, and the slot-3 word completed on the prior en edge is still delivered normally.
- fs missing at the expected position, FS_CHECK=0: continues as if fs were present.
- sync_err:
  - Cleared by clr_err=1 on any edge, regardless of en.
  - A new error on the same edge as clr_err wins: sync_err stays 1.
- ch_valid never has more than one bit set.
- rst asserted mid-word: immediate return to the reset state; no partial word is written.

Test Plan (W=8, FS_CHECK=1, en=1 unless stated):
- Clean frame: after reset, send fs with bytes A5, 3C, 0F, F0 MSB-first.
  - Required: ch0..3 = A5, 3C, 0F, F0.
  - ch_valid = 0001, 0010, 0100, 1000 on bit-edges 8, 16, 24, 32.
  - frame_done is high with 1000; locked = 1; sync_err = 0.
- en gating: same frame with en=0 on every other cycle.
  - Required: identical channel values; 0 valids on en=0 edges; outputs held.
- Early fs: fs reasserted at slot 1 bit 3.
  - Required: sync_err=1, no ch1 update, the bit realigned as slot 0.
  - The next 8 bits 81 land in ch0 with ch_valid 0001.
- Missing fs: second frame sent without fs.
  - Required: ch3 of frame 1 delivered; then locked=0, slot=0, sync_err=1.
  - Subsequent bits are ignored until the next fs.
- clr_err: assert clr_err with en=0.
  - Required: sync_err 0 next cycle.
  - clr_err together with an early fs leaves sync_err=1.
- Async reset mid-slot (bit 5 of slot 2): rst pulsed between edges.
  - Required: outputs 0 immediately, with no clock edge.
  - HUNT state; ch2 keeps reset value 00 until a new complete frame.
